// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receive/transmit paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    localparam int DATA_BITS = 8;

    // Clocks per oversample tick, truncated; never below 1.
    function automatic int div_calc(input int clock_hz, input int baud, input int oversample);
        int d;
        d = clock_hz / (baud * oversample);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider producing a one-cycle tick every DIV clocks.
// 'clear' restarts the count so a new frame gets a phase-aligned tick stream.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clock_input,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Divider counter: wraps at DIV-1, restarts on clear.
    always_ff @(posedge clock_input or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: synchronises and oversamples the rx line, deframes bytes
// (LSB first) and holds each byte in a one-entry valid/ready buffer.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit and a
// parity_error pulse output; without it the frame is plain 8N1.
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int CLOCK_HZ   = 16_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clock_input,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       framing_error,
    output logic       overrun,
`ifdef UART_RX_PARITY_EN
    output logic       parity_error,
`endif
    output logic       busy
);

    localparam int DIV = div_calc(CLOCK_HZ, BAUD, OVERSAMPLE);
    localparam int OSW = $clog2(OVERSAMPLE);
    localparam int BCW = $clog2(DATA_BITS);
    localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
    localparam logic [OSW-1:0] OS_HALF = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);

    logic                 rx_meta, rx_s;
    state_t               state, state_nxt;
    logic                 tick, tick_clr, bit_end;
    logic [OSW-1:0]       os_cnt;
    logic [BCW-1:0]       bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 deliver_q;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad;
`endif

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clock_input (clock_input),
        .reset_n     (reset_n),
        .clear       (tick_clr),
        .tick        (tick)
    );

    // Two-flop synchroniser; idles high like the line.
    always_ff @(posedge clock_input or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Start bit is sampled at mid-bit (half period), every later bit a full period on.
    assign bit_end = tick && (os_cnt == ((state == START) ? OS_HALF : OS_LAST));
    assign busy    = (state != IDLE);

    // State register.
    always_ff @(posedge clock_input or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; a falling edge in IDLE also realigns the tick divider.
    always_comb begin
        state_nxt = state;
        tick_clr  = 1'b0;
        case (state)
            IDLE:   if (!rx_s) begin
                        state_nxt = START;
                        tick_clr  = 1'b1;
                    end
            START:  if (bit_end) state_nxt = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:   if (bit_end && bit_cnt == BIT_LAST) state_nxt = PARITY;
            PARITY: if (bit_end) state_nxt = STOP;
`else
            DATA:   if (bit_end && bit_cnt == BIT_LAST) state_nxt = STOP;
`endif
            STOP:   if (bit_end) state_nxt = rx_s ? IDLE : BREAK;
            BREAK:  if (rx_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Oversample/bit counters and LSB-first shift register.
    always_ff @(posedge clock_input or negedge reset_n) begin
        if (!reset_n) begin
            os_cnt  <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            if (state == IDLE || bit_end) os_cnt <= '0;
            else if (tick)                os_cnt <= os_cnt + 1'b1;

            if (state != DATA)  bit_cnt <= '0;
            else if (bit_end)   bit_cnt <= bit_cnt + 1'b1;

            if (state == DATA && bit_end) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
        end
    end

    // Stop-bit outcome: deliver next cycle, or flag a framing error.
    always_ff @(posedge clock_input or negedge reset_n) begin
        if (!reset_n) begin
            framing_error <= 1'b0;
            deliver_q     <= 1'b0;
        end else begin
            framing_error <= (state == STOP) && bit_end && !rx_s;
`ifdef UART_RX_PARITY_EN
            deliver_q     <= (state == STOP) && bit_end && rx_s && !par_bad;
`else
            deliver_q     <= (state == STOP) && bit_end && rx_s;
`endif
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: the XOR of data and parity bit must be 0. A bad byte still
    // runs through STOP so the frame ends where the sender thinks it does.
    always_ff @(posedge clock_input or negedge reset_n) begin
        if (!reset_n) begin
            parity_error <= 1'b0;
            par_bad      <= 1'b0;
        end else begin
            parity_error <= (state == PARITY) && bit_end && ((^shreg) != rx_s);
            if (state == IDLE)                par_bad <= 1'b0;
            else if (state == PARITY && bit_end) par_bad <= ((^shreg) != rx_s);
        end
    end
`endif

    // One-entry output buffer; a held byte is never overwritten, the new one is dropped.
    always_ff @(posedge clock_input or negedge reset_n) begin
        if (!reset_n) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else if (deliver_q && (!rx_valid || rx_ready)) begin
            rx_data  <= shreg;
            rx_valid <= 1'b1;
        end else begin
            if (deliver_q)            overrun  <= 1'b1;
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Bench for uart_rx_frontend: 500 kBd at 16 MHz, 16x oversampling (32 clocks/bit).
// Expected bytes are queued by the stimulus; a negedge monitor pops them on handshake.
module tb_uart_rx_frontend;

    localparam int BIT = 32;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       framing_error;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_error;
    int         pe_count = 0;
`endif

    int checks = 0;
    int errors = 0;
    int hs_count = 0;
    int fe_count = 0;
    int fe_long = 0;
    logic [7:0] sb[$];

    logic       prev_valid = 1'b0;
    logic       prev_hs = 1'b0;
    logic [7:0] prev_data = '0;
    logic       fe_prev = 1'b0;

    uart_rx_frontend #(
        .CLOCK_HZ   (16_000_000),
        .BAUD       (500_000),
        .OVERSAMPLE (16)
    ) dut (
        .clock_input   (clk),
        .reset_n       (reset_n),
        .rx            (rx),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .framing_error (framing_error),
        .overrun       (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_error  (parity_error),
`endif
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance n rising edges and step just past the last one.
    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Frame: start, 8 data LSB first, [even parity], stop, back to idle high.
    task automatic send_raw(input logic [7:0] b, input logic par, input logic stop_bit);
        rx = 1'b0;
        clk_n(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            clk_n(BIT);
        end
`ifdef UART_RX_PARITY_EN
        rx = par;
        clk_n(BIT);
`else
        if (par) rx = 1'b1;
`endif
        rx = stop_bit;
        clk_n(BIT);
        rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        send_raw(b, ^b, stop_bit);
    endtask

    // Monitor: scoreboard pops on handshake, plus pulse/stability tracking.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
            fe_prev    = 1'b0;
        end else begin
            if (rx_valid && rx_ready) begin
                hs_count++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %02h expected none", rx_data);
                end else begin
                    chk("sb_byte", {24'h0, rx_data}, {24'h0, sb.pop_front()});
                end
            end
            if (prev_valid && !prev_hs)
                chk("data_stable", {23'h0, rx_valid, rx_data}, {23'h0, 1'b1, prev_data});
            if (framing_error) begin
                fe_count++;
                if (fe_prev) fe_long++;
            end
            fe_prev = framing_error;
`ifdef UART_RX_PARITY_EN
            if (parity_error) pe_count++;
`endif
            prev_valid = rx_valid;
            prev_hs    = rx_valid && rx_ready;
            prev_data  = rx_data;
        end
    end

    initial begin
        rx       = 1'b1;
        rx_ready = 1'b0;
        reset_n  = 1'b0;
        clk_n(3);
        chk("rst_data",    {24'h0, rx_data}, 32'h0);
        chk("rst_valid",   {31'h0, rx_valid}, 32'h0);
        chk("rst_fe",      {31'h0, framing_error}, 32'h0);
        chk("rst_overrun", {31'h0, overrun}, 32'h0);
        chk("rst_busy",    {31'h0, busy}, 32'h0);
        reset_n = 1'b1;
        clk_n(5);
        chk("idle_busy",   {31'h0, busy}, 32'h0);

        // 0xA5 with consumer always ready.
        rx_ready = 1'b1;
        sb.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        clk_n(20);
        chk("a5_count",   hs_count, 1);
        chk("a5_fe",      fe_count, 0);
        chk("a5_overrun", {31'h0, overrun}, 32'h0);
        chk("a5_valid",   {31'h0, rx_valid}, 32'h0);

        // Back-to-back 0x3C, 0xC3 with consumer stalled: second byte dropped.
        rx_ready = 1'b0;
        sb.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        clk_n(10);
        chk("ovr_valid",   {31'h0, rx_valid}, 32'h1);
        chk("ovr_data",    {24'h0, rx_data}, 32'h3C);
        chk("ovr_flag",    {31'h0, overrun}, 32'h1);
        rx_ready = 1'b1;
        clk_n(1);
        rx_ready = 1'b0;
        chk("ovr_release", {31'h0, rx_valid}, 32'h0);
        chk("ovr_count",   hs_count, 2);

        // 10-clock low glitch: rejected at the start-bit sample.
        rx = 1'b0;
        clk_n(8);
        chk("glitch_busy", {31'h0, busy}, 32'h1);
        clk_n(2);
        rx = 1'b1;
        clk_n(60);
        chk("glitch_idle",  {31'h0, busy}, 32'h0);
        chk("glitch_count", hs_count, 2);
        chk("glitch_fe",    fe_count, 0);
        chk("glitch_valid", {31'h0, rx_valid}, 32'h0);

        // 0x55 with a low stop bit, then recovery with 0x12.
        rx_ready = 1'b1;
        send_frame(8'h55, 1'b0);
        clk_n(40);
        chk("fe_count", fe_count, 1);
        chk("fe_width", fe_long, 0);
        chk("fe_nobyte", hs_count, 2);
        chk("fe_valid", {31'h0, rx_valid}, 32'h0);
        sb.push_back(8'h12);
        send_frame(8'h12, 1'b1);
        clk_n(20);
        chk("after_fe_count", hs_count, 3);
        chk("after_fe_data",  {24'h0, rx_data}, 32'h12);

        // Reset in the middle of 0xFF, then 0x81.
        rx = 1'b0;
        clk_n(BIT);
        rx = 1'b1;
        clk_n(BIT * 3);
        reset_n = 1'b0;
        clk_n(2);
        chk("mid_rst_data",    {24'h0, rx_data}, 32'h0);
        chk("mid_rst_valid",   {31'h0, rx_valid}, 32'h0);
        chk("mid_rst_fe",      {31'h0, framing_error}, 32'h0);
        chk("mid_rst_overrun", {31'h0, overrun}, 32'h0);
        chk("mid_rst_busy",    {31'h0, busy}, 32'h0);
        clk_n(3);
        reset_n = 1'b1;
        clk_n(BIT * 8);
        sb.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        clk_n(20);
        chk("post_rst_count",   hs_count, 4);
        chk("post_rst_data",    {24'h0, rx_data}, 32'h81);
        chk("post_rst_overrun", {31'h0, overrun}, 32'h0);
        chk("post_rst_fe",      fe_count, 1);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones: even parity bit must be 1.
        send_raw(8'h07, 1'b0, 1'b1);
        clk_n(20);
        chk("par_bad_pulse", pe_count, 1);
        chk("par_bad_count", hs_count, 4);
        chk("par_bad_valid", {31'h0, rx_valid}, 32'h0);
        sb.push_back(8'h07);
        send_raw(8'h07, 1'b1, 1'b1);
        clk_n(20);
        chk("par_ok_count", hs_count, 5);
        chk("par_ok_data",  {24'h0, rx_data}, 32'h07);
        chk("par_ok_pulse", pe_count, 1);
`endif

        clk_n(5);
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
